// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg
//   Shared types for the CPU bus arbiter: arbiter state encoding, requester
//   port identifiers, the full-word byte-enable constant and a word-align helper.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_id_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Avalon word addressing: the bus never sees the byte offset.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_cpu_bus_arbiter_if.sv
// mips_cpu_bus_arbiter_if
//   Avalon-MM master bus between the arbiter and external memory.
//   master modport: arbiter side (drives address/read/write/writedata/byteenable,
//                   receives readdata/waitrequest)
//   slave modport : memory side (the reverse)
interface mips_cpu_bus_arbiter_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/mips_cpu_bus_watchdog.sv
// mips_cpu_bus_watchdog
//   Waitrequest timeout for the bus arbiter (only built with MIPS_ARB_TIMEOUT_EN).
//   Down-counter reloaded whenever run is low; expire is asserted in the
//   TIMEOUT_CYCLES-th consecutive cycle that run is high.
//   Ports: clk, reset (async active-low), run (bus stalled), expire (abort now).
module mips_cpu_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= LOAD;
    end else if (!run) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter
//   Shares the CPU's single Avalon-MM master between instruction fetch and
//   load/store. One transaction at a time, data has strict priority, bus
//   controls are registered and held stable across waitrequest, read data is
//   registered into the requester's rdata port.
//   Ports:
//     clk, reset (async active-low)
//     fetch_req/fetch_addr -> fetch_done/fetch_rdata
//     data_req/data_we/data_addr/data_wdata/data_be -> data_done/data_rdata
//     bus_err : pulses with *_done on an aborted access
//     avm     : Avalon-MM master modport
//   Optional: define MIPS_ARB_TIMEOUT_EN to abort an access after
//   TIMEOUT_CYCLES waitrequest cycles; otherwise the arbiter waits forever
//   and bus_err is tied low.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        bus_err,
  mips_cpu_bus_arbiter_if.master avm
);

  // state | meaning
  // IDLE  | bus free, choose next requester
  // FETCH | instruction read on the bus
  // DATA  | load/store on the bus
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_DATA  = DATA;

  logic [1:0] state;
  logic       grant_vld;
  port_id_t   grant_port;
  logic       abort;

  // A port whose done is pulsing this cycle is still being seen by its
  // requester with req high, so it must not be granted again yet.
  always_comb begin
    grant_vld  = 1'b0;
    grant_port = PORT_FETCH;
    if (data_req && !data_done) begin
      grant_vld  = 1'b1;
      grant_port = PORT_DATA;
    end else if (fetch_req && !fetch_done) begin
      grant_vld  = 1'b1;
    end
  end

`ifdef MIPS_ARB_TIMEOUT_EN
  logic wd_run;
  logic wd_expire;

  assign wd_run = (state != ST_IDLE) && avm.avm_waitrequest;

  mips_cpu_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .run    (wd_run),
    .expire (wd_expire)
  );

  assign abort = wd_expire;
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      avm.avm_address    <= '0;
      avm.avm_read       <= 1'b0;
      avm.avm_write      <= 1'b0;
      avm.avm_writedata  <= '0;
      avm.avm_byteenable <= '0;
      fetch_done         <= 1'b0;
      fetch_rdata        <= '0;
      data_done          <= 1'b0;
      data_rdata         <= '0;
`ifdef MIPS_ARB_TIMEOUT_EN
      bus_err            <= 1'b0;
`endif
    end else begin
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
`ifdef MIPS_ARB_TIMEOUT_EN
      bus_err    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            if (grant_port == PORT_DATA) begin
              state              <= ST_DATA;
              avm.avm_address    <= word_align(data_addr);
              avm.avm_writedata  <= data_wdata;
              avm.avm_byteenable <= data_be;
              avm.avm_read       <= !data_we;
              avm.avm_write      <= data_we;
            end else begin
              state              <= ST_FETCH;
              avm.avm_address    <= word_align(fetch_addr);
              avm.avm_byteenable <= BE_ALL;
              avm.avm_read       <= 1'b1;
              avm.avm_write      <= 1'b0;
            end
          end
        end
        ST_FETCH, ST_DATA: begin
          if (!avm.avm_waitrequest || abort) begin
            state         <= ST_IDLE;
            avm.avm_read  <= 1'b0;
            avm.avm_write <= 1'b0;
`ifdef MIPS_ARB_TIMEOUT_EN
            bus_err       <= avm.avm_waitrequest;
`endif
            if (state == ST_FETCH) begin
              fetch_done  <= 1'b1;
              fetch_rdata <= avm.avm_waitrequest ? '0 : avm.avm_readdata;
            end else begin
              data_done <= 1'b1;
              if (avm.avm_waitrequest) begin
                data_rdata <= '0;
              end else if (avm.avm_read) begin
                data_rdata <= avm.avm_readdata;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
module tb_mips_cpu_bus_arbiter;

`ifdef MIPS_ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_done;
  logic [31:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        bus_err;

  mips_cpu_bus_arbiter_if bus ();

  mips_cpu_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_done  (fetch_done),
    .fetch_rdata (fetch_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_be     (data_be),
    .data_done   (data_done),
    .data_rdata  (data_rdata),
    .bus_err     (bus_err),
    .avm         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents seen by any read: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // ---------------- slave model ----------------
  // wait_mode: 0 no stall, 1 random 0..3, 2 stuck, 3 fixed wait_fixed
  int wait_mode  = 0;
  int wait_fixed = 0;
  int stall_left = 0;
  bit armed      = 1'b0;

  assign bus.avm_readdata = mem_word(bus.avm_address);

  always @(posedge clk) begin
    #1;
    if (!(bus.avm_read || bus.avm_write)) begin
      armed = 1'b0;
      bus.avm_waitrequest = 1'b0;
    end else begin
      if (!armed) begin
        armed = 1'b1;
        case (wait_mode)
          0:       stall_left = 0;
          1:       stall_left = $urandom_range(0, 3);
          2:       stall_left = 1_000_000;
          default: stall_left = wait_fixed;
        endcase
      end
      bus.avm_waitrequest = (stall_left > 0);
      if (stall_left > 0) stall_left--;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dexp_t;

  logic [31:0] fetch_q[$];
  dexp_t       data_q[$];
  logic [31:0] exp_data_rdata = '0;

  logic        p_busy = 0, p_wait = 0, p_fdone = 0, p_ddone = 0, p_freq = 0, p_dreq = 0, p_rst = 0;
  logic        p_rd = 0, p_wr = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0]  p_be = '0;
  logic        lt_rd = 0, lt_wr = 0;
  logic [31:0] lt_addr = '0, lt_wdata = '0;
  logic [3:0]  lt_be = '0;

  always @(negedge clk) begin
    logic  busy;
    logic  ended_abort;
    logic [31:0] fa;
    dexp_t d;
    busy = bus.avm_read || bus.avm_write;
    ended_abort = p_busy && p_wait && !busy;
    if (!reset) begin
      fetch_q.delete();
      data_q.delete();
      exp_data_rdata = '0;
    end else if (p_rst) begin
      if (!p_busy) begin
        check("grant_timing", busy, (p_dreq && !p_ddone) || (p_freq && !p_fdone));
        if (busy) check("grant_priority", !bus.avm_address[31], p_dreq && !p_ddone);
      end
      if (p_busy && !p_wait) check("release_after_ready", busy, 1'b0);
      if (p_busy && p_wait && busy)
        check("hold_while_wait",
              {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_byteenable, bus.avm_writedata},
              {p_rd, p_wr, p_addr, p_be, p_wdata});
      if (ended_abort) check("abort_only_with_timeout", TMO_EN, 1'b1);
      if (busy && !bus.avm_waitrequest) begin
        lt_rd = bus.avm_read; lt_wr = bus.avm_write; lt_addr = bus.avm_address;
        lt_wdata = bus.avm_writedata; lt_be = bus.avm_byteenable;
      end
      if (bus_err && !fetch_done && !data_done) check("bus_err_without_done", 1'b1, 1'b0);
      if (fetch_done) begin
        check("fetch_done_pulse", p_fdone, 1'b0);
        check("fetch_bus_err", bus_err, ended_abort);
        if (fetch_q.size() == 0) begin
          check("fetch_unexpected_done", 1'b1, 1'b0);
        end else begin
          fa = fetch_q.pop_front();
          if (ended_abort) begin
            check("fetch_rdata_abort", fetch_rdata, 32'h0);
          end else begin
            check("fetch_bus_txn", {lt_rd, lt_wr, lt_addr, lt_be}, {1'b1, 1'b0, align(fa), 4'hF});
            check("fetch_rdata", fetch_rdata, mem_word(align(fa)));
          end
        end
      end
      if (data_done) begin
        check("data_done_pulse", p_ddone, 1'b0);
        check("data_bus_err", bus_err, ended_abort);
        if (data_q.size() == 0) begin
          check("data_unexpected_done", 1'b1, 1'b0);
        end else begin
          d = data_q.pop_front();
          if (ended_abort) begin
            exp_data_rdata = '0;
          end else begin
            check("data_bus_txn",
                  {lt_rd, lt_wr, lt_addr, lt_be, (d.we ? lt_wdata : 32'h0)},
                  {!d.we, d.we, align(d.addr), d.be, (d.we ? d.wdata : 32'h0)});
            if (!d.we) exp_data_rdata = mem_word(align(d.addr));
          end
          check("data_rdata", data_rdata, exp_data_rdata);
        end
      end
    end
    p_busy = busy; p_wait = bus.avm_waitrequest; p_fdone = fetch_done; p_ddone = data_done;
    p_freq = fetch_req; p_dreq = data_req; p_rst = reset;
    p_rd = bus.avm_read; p_wr = bus.avm_write; p_addr = bus.avm_address;
    p_be = bus.avm_byteenable; p_wdata = bus.avm_writedata;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_data();
    dexp_t d;
    d.we = data_we; d.addr = data_addr; d.wdata = data_wdata; d.be = data_be;
    data_q.push_back(d);
  endtask

  task automatic fetch_stream(input int n);
    int cyc;
    int gap;
    for (int i = 0; i < n; i++) begin
      fetch_addr = 32'hBFC0_0000 | ($urandom & 32'h0000_FFFF);
      fetch_req  = 1'b1;
      fetch_q.push_back(fetch_addr);
      cyc = 0;
      do begin tick(); cyc++; end while (!fetch_done && cyc < 300);
      if (!fetch_done) begin
        check("fetch_stream_timeout", 1'b0, 1'b1);
        fetch_req = 1'b0;
        return;
      end
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        fetch_req = 1'b0;
        repeat (gap) tick();
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic data_stream(input int n);
    int cyc;
    int gap;
    bit drop;
    for (int i = 0; i < n; i++) begin
      data_we    = 1'($urandom_range(0, 1));
      data_addr  = $urandom & 32'h0000_FFFF;
      data_wdata = $urandom;
      data_be    = 4'($urandom_range(1, 15));
      data_req   = 1'b1;
      drop       = ($urandom_range(0, 3) == 0);
      push_data();
      cyc = 0;
      do begin
        tick(); cyc++;
        if (drop && data_req && !data_done && (bus.avm_read || bus.avm_write) && !bus.avm_address[31])
          data_req = 1'b0;
      end while (!data_done && cyc < 300);
      if (!data_done) begin
        check("data_stream_timeout", 1'b0, 1'b1);
        data_req = 1'b0;
        return;
      end
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        data_req = 1'b0;
        repeat (gap) tick();
      end
    end
    data_req = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc;
    int cnt;
    int last;
    int ndone;
    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
    repeat (3) tick();

    // reset state
    check("reset_state",
          {bus.avm_read, bus.avm_write, fetch_done, data_done, bus_err, bus.avm_byteenable,
           bus.avm_address, bus.avm_writedata},
          '0);
    check("reset_rdata", {fetch_rdata, data_rdata}, '0);
    #2 reset = 1'b1;
    tick();

    // single fetch, zero wait
    fetch_addr = 32'hBFC0_0000; fetch_req = 1'b1; fetch_q.push_back(fetch_addr);
    tick();
    check("t1_bus_cycle", {bus.avm_read, bus.avm_address, bus.avm_byteenable}, {1'b1, 32'hBFC0_0000, 4'hF});
    tick();
    check("t1_done", {fetch_done, fetch_rdata}, {1'b1, 32'h2402_0005});
    fetch_req = 1'b0;
    tick();

    // simultaneous requests: data first, fetch granted in the data_done cycle
    data_addr = 32'h0000_2000; data_we = 1'b0; data_be = 4'hF; data_req = 1'b1; push_data();
    fetch_addr = 32'hBFC0_0040; fetch_req = 1'b1; fetch_q.push_back(fetch_addr);
    tick();
    check("t2_data_first", {bus.avm_read, bus.avm_address}, {1'b1, 32'h0000_2000});
    tick();
    check("t2_data_done", {data_done, data_rdata}, {1'b1, mem_word(32'h0000_2000)});
    data_req = 1'b0;
    tick();
    check("t2_fetch_bus", {bus.avm_read, bus.avm_address, bus.avm_byteenable}, {1'b1, 32'hBFC0_0040, 4'hF});
    tick();
    check("t2_fetch_done", fetch_done, 1'b1);
    fetch_req = 1'b0;
    tick();

    // write with three waitrequest cycles
    wait_mode = 3; wait_fixed = 3;
    data_addr = 32'h0000_1003; data_wdata = 32'hDEAD_BEEF; data_be = 4'b1000; data_we = 1'b1;
    data_req = 1'b1; push_data();
    cyc = 0; cnt = 0;
    do begin
      tick(); cyc++;
      if (bus.avm_write) cnt++;
    end while (!data_done && cyc < 50);
    check("t3_write_cycles", cnt, 4);
    check("t3_done_latency", cyc, 5);
    check("t3_rdata_unchanged", data_rdata, mem_word(32'h0000_2000));
    data_req = 1'b0; data_we = 1'b0;
    wait_mode = 0;
    tick();

    // async reset in the middle of a stalled read
    wait_mode = 2;
    fetch_addr = 32'hBFC0_0100; fetch_req = 1'b1; fetch_q.push_back(fetch_addr);
    tick();
    check("t4_read_active", bus.avm_read, 1'b1);
    tick();
    #2 reset = 1'b0;
    #1;
    check("t4_read_dropped", {bus.avm_read, bus.avm_write, fetch_done}, 3'b000);
    fetch_req = 1'b0;
    wait_mode = 0;
    tick();
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_idle_after_reset", {bus.avm_read, bus.avm_write, fetch_done, data_done}, 4'b0000);
    end

`ifdef MIPS_ARB_TIMEOUT_EN
    // stuck waitrequest aborts after TMO cycles
    wait_mode = 2;
    fetch_addr = 32'hBFC0_0200; fetch_req = 1'b1; fetch_q.push_back(fetch_addr);
    cyc = 0; cnt = 0;
    do begin
      tick(); cyc++;
      if (bus.avm_read) cnt++;
    end while (!fetch_done && cyc < 50);
    check("t6_read_cycles", cnt, TMO);
    check("t6_abort", {fetch_done, bus_err, fetch_rdata}, {1'b1, 1'b1, 32'h0});
    fetch_req = 1'b0;
    wait_mode = 0;
    tick();
`endif

    // data held continuously: done is never regranted, next access completes 3 cycles later
    data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0000_3000; data_req = 1'b1; push_data();
    cyc = 0; last = 0; ndone = 0;
    while (ndone < 3 && cyc < 60) begin
      tick(); cyc++;
      if (data_done) begin
        if (ndone > 0) check("t5_spacing", cyc - last, 3);
        last = cyc; ndone++;
        if (ndone < 3) begin
          data_addr = data_addr + 32'd4;
          push_data();
        end else begin
          data_req = 1'b0;
        end
      end
    end
    check("t5_count", ndone, 3);
    data_req = 1'b0;
    tick();

    // randomized concurrent traffic with random stalls
    wait_mode = 1;
    fork
      fetch_stream(40);
      data_stream(40);
    join
    wait_mode = 0;
    repeat (6) tick();
    check("fetch_q_drained", fetch_q.size(), 0);
    check("data_q_drained", data_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
